// File: rtl/alu_pkg.sv
// Shared opcode/state encodings for the sequential ALU.
// Opcodes 000-100 keep the encodings of the earlier combinational ALU.
package alu_pkg;

  localparam int unsigned OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_EOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DONE
  } alu_state_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor: sum = a + (sub ? ~b + 1 : b).
// Reports carry out (1 = no borrow on subtract) and two's-complement overflow.
module alu_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff                = sub ? ~b : b;
    {carry_out, sum}     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    // Operands of equal sign producing a result of the other sign.
    overflow             = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags; single-cycle ops land in DONE
// one edge after acceptance, MUL iterates one multiplier bit per edge.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  alu_state_e           state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, acc_next;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  alu_op_e              op;
  logic                 accept, mul_last;
  logic [WIDTH-1:0]     as_sum, alu_res;
  logic                 as_cout, as_ovf, alu_c, alu_v;
  logic [2*WIDTH-1:0]   mul_sum;
  logic                 mul_cout, mul_ovf, unused_mul;

  assign op         = alu_op_e'(opcode);
  assign accept     = in_valid && in_ready;
  assign mul_last   = (cnt_q == CntW'(WIDTH - 1));
  assign unused_mul = mul_cout ^ mul_ovf;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a         (a),
    .b         (b),
    .sub       (op == OP_SUB),
    .sum       (as_sum),
    .carry_out (as_cout),
    .overflow  (as_ovf)
  );

  alu_addsub #(.WIDTH(2 * WIDTH)) u_mul_acc (
    .a         (acc_q),
    .b         (mcand_q),
    .sub       (1'b0),
    .sum       (mul_sum),
    .carry_out (mul_cout),
    .overflow  (mul_ovf)
  );

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB: begin
        alu_res = as_sum;
        alu_c   = as_cout;
        alu_v   = as_ovf;
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_EOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      OP_MUL: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
      n_q      <= n_d;
      v_q      <= v_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (op == OP_MUL) ? MUL_RUN : DONE;
      MUL_RUN: if (mul_last) state_d = DONE;
      DONE: begin
        // in_ready follows out_ready here, so an accept also consumes the result.
        if (accept)         state_d = (op == OP_MUL) ? MUL_RUN : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    result_d = result_q;
    z_d      = z_q;
    c_d      = c_q;
    n_d      = n_q;
    v_d      = v_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_next = mplier_q[0] ? mul_sum : acc_q;
    if (accept) begin
      if (op == OP_MUL) begin
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        cnt_d    = '0;
      end else begin
        result_d = alu_res;
        z_d      = (alu_res == '0);
        c_d      = alu_c;
        n_d      = alu_res[WIDTH-1];
        v_d      = alu_v;
      end
    end else if (state_q == MUL_RUN) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (mul_last) begin
        result_d = acc_next[WIDTH-1:0];
        z_d      = (acc_next[WIDTH-1:0] == '0);
        c_d      = |acc_next[2*WIDTH-1:WIDTH];
        n_d      = acc_next[WIDTH-1];
        v_d      = 1'b0;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
    busy      = (state_q == MUL_RUN);
    result    = result_q;
    flag_z    = z_q;
    flag_c    = c_q;
    flag_n    = n_q;
    flag_v    = v_q;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: 8-bit and 16-bit instances share stimulus, selected by sel16.
// Directed vector table, handshake corner sequences and random ops against a model.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        n;
    logic        v;
  } exp_t;

  typedef struct {
    alu_op_e     op;
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        sel16 = 1'b0;
  logic [2:0]  opcode = 3'b000;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic        rdy8, ov8, busy8, z8, c8, n8, v8;
  logic [7:0]  res8;
  logic        rdy16, ov16, busy16, z16, c16, n16, v16;
  logic [15:0] res16;

  logic        in_ready_m, out_valid_m, busy_m;
  logic [15:0] result_m;
  logic [3:0]  flags_m;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && !sel16),
    .in_ready  (rdy8),
    .a         (a[7:0]),
    .b         (b[7:0]),
    .opcode    (opcode),
    .out_valid (ov8),
    .out_ready (out_ready),
    .result    (res8),
    .flag_z    (z8),
    .flag_c    (c8),
    .flag_n    (n8),
    .flag_v    (v8),
    .busy      (busy8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && sel16),
    .in_ready  (rdy16),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (ov16),
    .out_ready (out_ready),
    .result    (res16),
    .flag_z    (z16),
    .flag_c    (c16),
    .flag_n    (n16),
    .flag_v    (v16),
    .busy      (busy16)
  );

  assign in_ready_m  = sel16 ? rdy16 : rdy8;
  assign out_valid_m = sel16 ? ov16 : ov8;
  assign busy_m      = sel16 ? busy16 : busy8;
  assign result_m    = sel16 ? res16 : {8'h00, res8};
  assign flags_m     = sel16 ? {z16, c16, n16, v16} : {z8, c8, n8, v8};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic z, c, n, v);
    exp_t e;
    e.res = r; e.z = z; e.c = c; e.n = n; e.v = v;
    return e;
  endfunction

  // Plain-integer reference: unsigned value for result/carry, signed value for overflow.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] ia, ib, input int w);
    longint m, lim, av, bv, sa, sb, full, sv, r;
    logic   c, v;
    exp_t   e;
    m   = (64'sd1 <<< w) - 1;
    lim = 64'sd1 <<< (w - 1);
    av  = longint'(ia) & m;
    bv  = longint'(ib) & m;
    sa  = (av >= lim) ? av - 2 * lim : av;
    sb  = (bv >= lim) ? bv - 2 * lim : bv;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      3'd0: begin
        full = av + bv; r = full & m; c = full > m;
        sv = sa + sb; v = (sv >= lim) || (sv < -lim);
      end
      3'd1: begin
        full = av + (~bv & m) + 1; r = full & m; c = full > m;
        sv = sa - sb; v = (sv >= lim) || (sv < -lim);
      end
      3'd2: r = av & bv;
      3'd3: r = av | bv;
      3'd4: r = av ^ bv;
      3'd5: begin r = (av * 2) & m; c = av >= lim; end
      3'd6: begin r = av / 2; c = (av % 2) == 1; end
      default: begin full = av * bv; r = full & m; c = full > m; end
    endcase
    e = mk(16'(r), r == 0, c, r >= lim, v);
    return e;
  endfunction

  // Issue one op on the selected instance, check latency/busy, hold off out_ready for
  // `stall` cycles checking stability, then consume. Entered and left at #1 after an edge.
  task automatic do_op(input logic [2:0] op, input logic [15:0] ia, ib, input int stall,
                       input exp_t e, input string tag);
    int w, n;
    logic rdy_ok;
    w = sel16 ? 16 : 8;
    opcode    = op;
    a         = ia;
    b         = ib;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    #1;
    n = 0;
    while (!in_ready_m && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, ".accept_ready"}, in_ready_m, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (op == 3'b111) begin
      n = 0;
      rdy_ok = 1'b1;
      while (busy_m && n < 100) begin
        if (in_ready_m) rdy_ok = 1'b0;
        @(posedge clk); #1; n++;
      end
      chk({tag, ".busy_cycles"}, n, w);
      chk({tag, ".ready_low_busy"}, rdy_ok, 1);
    end
    chk({tag, ".out_valid"}, out_valid_m, 1);
    chk({tag, ".result"}, result_m, e.res);
    chk({tag, ".flags_zcnv"}, flags_m, {e.z, e.c, e.n, e.v});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, ".held_result"}, result_m, e.res);
      chk({tag, ".held_flags"}, flags_m, {e.z, e.c, e.n, e.v});
      chk({tag, ".held_ready"}, {out_valid_m, in_ready_m}, 2'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".drained"}, out_valid_m, 0);
  endtask

  initial begin
    vec_t vecs[12];
    exp_t e;
    int   n;
    logic [2:0] rop;
    logic [15:0] ra, rb;

    vecs[0]  = '{OP_ADD, 16'h7F, 16'h01, mk(16'h80, 0, 0, 1, 1)};
    vecs[1]  = '{OP_SUB, 16'h05, 16'h05, mk(16'h00, 1, 1, 0, 0)};
    vecs[2]  = '{OP_SUB, 16'h00, 16'h01, mk(16'hFF, 0, 0, 1, 0)};
    vecs[3]  = '{OP_SUB, 16'h80, 16'h01, mk(16'h7F, 0, 1, 0, 1)};
    vecs[4]  = '{OP_MUL, 16'h0F, 16'h11, mk(16'hFF, 0, 0, 1, 0)};
    vecs[5]  = '{OP_MUL, 16'h10, 16'h10, mk(16'h00, 1, 1, 0, 0)};
    vecs[6]  = '{OP_SHL, 16'h81, 16'h5A, mk(16'h02, 0, 1, 0, 0)};
    vecs[7]  = '{OP_SHR, 16'h01, 16'hFF, mk(16'h00, 1, 1, 0, 0)};
    vecs[8]  = '{OP_EOR, 16'hAA, 16'hAA, mk(16'h00, 1, 0, 0, 0)};
    vecs[9]  = '{OP_AND, 16'hF0, 16'h3C, mk(16'h30, 0, 0, 0, 0)};
    vecs[10] = '{OP_OR,  16'h0F, 16'hF0, mk(16'hFF, 0, 0, 1, 0)};
    vecs[11] = '{OP_ADD, 16'hFF, 16'h01, mk(16'h00, 1, 1, 0, 0)};

    repeat (3) @(posedge clk);
    #1;
    chk("rst8.state", {result_m, flags_m, out_valid_m, busy_m, in_ready_m}, 23'h1);
    sel16 = 1'b1; #1;
    chk("rst16.state", {result_m, flags_m, out_valid_m, busy_m, in_ready_m}, 23'h1);
    sel16 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, vecs[i].e, $sformatf("vec%0d", i));

    // Stalled ADD, then OR accepted on the same edge that consumes it: no bubble.
    opcode = OP_ADD; a = 16'h01; b = 16'h02; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    opcode = OP_OR; a = 16'hF0; b = 16'h0F;
    for (int i = 0; i < 3; i++) begin
      chk("bp.held", {result_m, out_valid_m, in_ready_m}, {16'h0003, 2'b10});
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    chk("bp.ready_follows", in_ready_m, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.nobubble", {out_valid_m, result_m, flags_m}, {1'b1, 16'h00FF, 4'b0010});
    @(posedge clk); #1;
    chk("bp.drained", out_valid_m, 0);

    // Reset after four MUL iterations discards the operation.
    opcode = OP_MUL; a = 16'h0F; b = 16'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rstmul.busy_before", busy_m, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstmul.state", {result_m, flags_m, out_valid_m, busy_m, in_ready_m}, 23'h1);
    rst_n = 1'b1;
    do_op(OP_ADD, 16'h02, 16'h03, 0, mk(16'h05, 0, 0, 0, 0), "rstmul.add");

    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom_range(0, 255));
      rb  = 16'($urandom_range(0, 255));
      n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_op(rop, ra, rb, n, model(rop, ra, rb, 8), $sformatf("rnd8_%0d", i));
    end

    sel16 = 1'b1;
    do_op(OP_MUL, 16'h00FF, 16'h0101, 0, mk(16'hFFFF, 0, 0, 1, 0), "w16.mul");
    do_op(OP_ADD, 16'h7FFF, 16'h0001, 0, mk(16'h8000, 0, 0, 1, 1), "w16.add");
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_op(rop, ra, rb, n, model(rop, ra, rb, 16), $sformatf("rnd16_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the 8-bit combinational ALU, and the next-generation ALU for the datapath.
- Keeps the existing opcode encodings 000–100 (ADD, SUB, AND, OR, EOR) and the Z/C flag semantics.
- Adds shifts, an iterative shift-add multiplier, N/V flags and registered outputs.
- Uses valid/ready handshakes on both input and output, so it can sit between the register-file read stage and the writeback stage with back-pressure.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept a request this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 EOR, 101 SHL, 110 SHR, 111 MUL
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  registered result
- flag_z  out  1  result == 0
- flag_c  out  1  carry / shifted-out bit / MUL high-half nonzero
- flag_n  out  1  result[WIDTH-1]
- flag_v  out  1  signed overflow (ADD/SUB only)
- busy  out  1  high while a MUL is iterating

Behaviour:
- Reset: clk and rst_n are the single clock and synchronous active-low reset. While rst_n=0 at a rising edge, the next state is as follows:
  - state IDLE;
  - result, all flags, out_valid and busy = 0;
  - in_ready = 1 after that edge.
- Reset mid-operation: reset during a MUL or while DONE holds a result discards the work without completing it.
- States:
  - IDLE: in_ready=1.
  - MUL_RUN: in_ready=0, busy=1.
  - DONE: out_valid=1; outputs held stable until accepted.
- Accept: an operation is accepted on an edge with in_valid && in_ready. Operands and opcode are captured at that edge. in_ready = (state==IDLE) || (state==DONE && out_ready).
- Single-cycle ops (000–110):
  - Accepted at edge e → DONE with result/flags registered at e.
  - out_valid is visible the cycle after e, giving 1-cycle latency.
- MUL:
  - Accepted at edge e → MUL_RUN.
  - Each later edge processes one multiplier bit, LSB first: accumulator += multiplicand if the bit is set, then the multiplicand shifts left and the multiplier shifts right.
  - After WIDTH such edges → DONE. out_valid is first visible WIDTH+1 cycles after acceptance; the first valid cycle follows edge e+WIDTH.
  - The accumulator is 2*WIDTH bits. result = low WIDTH bits; flag_c = |high WIDTH bits; flag_v=0.
- DONE exit:
  - On an edge with out_ready=1, the result is consumed.
  - If the same edge also accepts a new op, the block goes to DONE (single-cycle op) or MUL_RUN (MUL) with no bubble. Otherwise it goes to IDLE and out_valid drops.
  - With out_ready=0, result and flags stay bit-for-bit stable.
- Arithmetic (WIDTH bits, modulo 2^WIDTH):
  - ADD: a+b. C = carry out. V = (a msb == b msb) && (res msb != a msb).
  - SUB: a+~b+1. C = carry out (1 = no borrow). V = (a msb != b msb) && (res msb != a msb).
  - AND/OR/EOR: bitwise; C=0, V=0.
  - SHL: a<<1; C = a[WIDTH-1]. SHR: logical a>>1; C = a[0]. For both, b is ignored and V=0.
- All ops: Z = (result==0); N = result[WIDTH-1].
- No X propagation: every opcode is defined.
- in_valid while in_ready=0 has no effect; the requester must hold it.

Decomposition:
- Package alu_pkg:
  - opcode enum alu_op_e (OP_ADD..OP_MUL, 3 bits);
  - state enum alu_state_e (IDLE, MUL_RUN, DONE);
  - localparam OPW=3.
- Sub-module alu_addsub #(WIDTH): combinational adder/subtractor with a subtract input. Outputs are sum, carry_out and overflow. It is reused for ADD/SUB and for the MUL accumulate (with WIDTH widened to 2*WIDTH).
- The FSM, multiplier registers, output registers and handshake live in alu_seq.

Test Plan:
1. WIDTH=8, ADD a=0x7F b=0x01, out_ready=1 → result 0x80, Z0 C0 N1 V1. out_valid is first visible the cycle after acceptance and in_ready stays 1.
2. SUB a=0x05 b=0x05 → 0x00, Z1 C1 N0 V0. Then SUB a=0x00 b=0x01 → 0xFF, Z0 C0 N1 V0. Then SUB a=0x80 b=0x01 → 0x7F, V1.
3. MUL a=0x0F b=0x11:
   - → 0xFF, C0; busy=1 and in_ready=0 for 8 cycles; out_valid first visible 9 cycles after acceptance.
   - MUL 0x10*0x10 → 0x00, Z1 C1.
   - Repeat with WIDTH=16: 0x00FF*0x0101 → 0xFFFF, C0, busy for 16 cycles.
4. SHL a=0x81 → 0x02, C1. SHR a=0x01 → 0x00, Z1 C1. EOR 0xAA^0xAA → 0x00, Z1 C0.
5. Back-pressure:
   - ADD 0x01+0x02 with out_ready=0 for 3 cycles → result 0x03 held stable, in_ready=0.
   - Then out_ready=1 with in_valid=1 OR 0xF0|0x0F → next cycle result 0xFF, out_valid remains 1 with no bubble.
6. Reset mid-MUL: assert rst_n=0 after 4 iterations.
   - → after the reset edge, result=0, all flags 0, out_valid=0, busy=0, in_ready=1.
   - A following ADD 0x02+0x03 → 0x05.
